// File: rtl/btn_pkg.sv
// Shared types and parameter helpers for the button conditioner.
// Repeat-state encoding plus counter-width sanity helpers.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DELAY,
    ST_RPT
  } rpt_state_t;

  function automatic longint unsigned max3(
    input longint unsigned a,
    input longint unsigned b,
    input longint unsigned c
  );
    longint unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // True when a cnt_w-bit counter can reach every terminal count.
  function automatic bit cnt_w_ok(
    input int unsigned     cnt_w,
    input longint unsigned a,
    input longint unsigned b,
    input longint unsigned c
  );
    return ((max3(a, b, c) - 1) >> cnt_w) == 0;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop sync, debounce counter and auto-repeat FSM.
// Press, release and repeat pulses are registered, one cycle wide.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 12500000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_rpt_en,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  rpt_state_t       r_state;
  logic [CNT_W-1:0] r_rcnt;
  logic             r_press;
  logic             r_release;

  logic             w_diff;
  logic             w_flip;
  logic             w_rise;
  logic             w_fall;
  rpt_state_t       w_state_nx;
  logic [CNT_W-1:0] w_rcnt_nx;
  logic             w_rpt;

  assign w_diff = r_sync2 ^ r_stable;
  assign w_flip = w_diff && (r_cnt == DEB_LAST);
  assign w_rise = w_flip && !r_stable;
  assign w_fall = w_flip && r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_diff || w_flip) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
      if (w_flip) r_stable <= ~r_stable;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rcnt    <= w_rcnt_nx;
      r_press   <= w_rise | w_rpt;
      r_release <= w_fall;
    end
  end

  // A falling level overrides everything, so no repeat lands on release.
  always_comb begin
    w_state_nx = r_state;
    w_rcnt_nx  = r_rcnt;
    w_rpt      = 1'b0;
    if (w_fall) begin
      w_state_nx = ST_IDLE;
      w_rcnt_nx  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nx = i_rpt_en ? ST_DELAY : ST_HOLD;
            w_rcnt_nx  = '0;
          end
        end
        ST_HOLD: begin
          if (i_rpt_en) begin
            w_state_nx = ST_DELAY;
            w_rcnt_nx  = '0;
          end
        end
        ST_DELAY: begin
          if (!i_rpt_en) begin
            w_state_nx = ST_HOLD;
            w_rcnt_nx  = '0;
          end else if (r_rcnt == DLY_LAST) begin
            w_state_nx = ST_RPT;
            w_rcnt_nx  = '0;
            w_rpt      = 1'b1;
          end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
          end
        end
        ST_RPT: begin
          if (!i_rpt_en) begin
            w_state_nx = ST_HOLD;
            w_rcnt_nx  = '0;
          end else if (r_rcnt == PER_LAST) begin
            w_rcnt_nx = '0;
            w_rpt     = 1'b1;
          end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_rcnt_nx  = '0;
        end
      endcase
    end
  end

  assign o_level   = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// Bank of independent button channels feeding the game FSM.
// Pure structure: one btn_channel per raw input bit.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 12500000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_raw     (btn_raw[g]),
      .i_rpt_en  (repeat_en[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g])
    );
  end

endmodule
